// File: rtl/arbitro_destino.sv
// ============================================================================
// Module   : arbitro_destino
// Brief    : Drains the intermediate FIFO one word at a time and routes each
//            word to one of four output FIFOs by its destination field.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbitro_destino #(
    parameter int DATA_WIDTH = 6,
    parameter int DEST_LSB   = 4,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic [3:0]            state,
    input  logic                  empty_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  almost_full0,
    input  logic                  almost_full1,
    input  logic                  almost_full2,
    input  logic                  almost_full3,
    output logic                  pop,
    output logic                  push0,
    output logic                  push1,
    output logic                  push2,
    output logic                  push3,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [CNT_WIDTH-1:0]  cnt0,
    output logic [CNT_WIDTH-1:0]  cnt1,
    output logic [CNT_WIDTH-1:0]  cnt2,
    output logic [CNT_WIDTH-1:0]  cnt3,
    output logic                  busy
);

    localparam logic [3:0] GLOBAL_ACTIVE = 4'b1000;
    localparam int         NUM_DEST      = 4;

    typedef enum logic [3:0] {
        S_IDLE    = 4'b0001,
        S_FETCH   = 4'b0010,
        S_CAPTURE = 4'b0100,
        S_SEND    = 4'b1000
    } fsm_t;

    fsm_t                  fsm_q, fsm_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [1:0]            dest_q, dest_d;
    logic [CNT_WIDTH-1:0]  cnt_q [NUM_DEST];
    logic [CNT_WIDTH-1:0]  cnt_d [NUM_DEST];
    logic [NUM_DEST-1:0]   push_vec;
    logic [NUM_DEST-1:0]   almost_full_vec;
    logic                  can_fetch;

    assign almost_full_vec = {almost_full3, almost_full2, almost_full1, almost_full0};

    // The emptiness check is made the cycle before the pop, so pop itself
    // depends on the FSM state alone.
    assign can_fetch = (state == GLOBAL_ACTIVE) && !empty_in;

    always_comb begin
        fsm_d    = fsm_q;
        hold_d   = hold_q;
        dest_d   = dest_q;
        push_vec = '0;
        for (int i = 0; i < NUM_DEST; i++) begin
            cnt_d[i] = cnt_q[i];
        end

        case (fsm_q)
            S_IDLE: begin
                if (can_fetch) begin
                    fsm_d = S_FETCH;
                end
            end
            S_FETCH: begin
                fsm_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                hold_d = data_in;
                dest_d = data_in[DEST_LSB+1:DEST_LSB];
                fsm_d  = S_SEND;
            end
            S_SEND: begin
                // Only the addressed FIFO's almost_full can stall delivery.
                if (!almost_full_vec[dest_q]) begin
                    push_vec[dest_q] = 1'b1;
                    cnt_d[dest_q]    = cnt_q[dest_q] + CNT_WIDTH'(1);
                    fsm_d            = can_fetch ? S_FETCH : S_IDLE;
                end
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            fsm_q  <= S_IDLE;
            hold_q <= '0;
            dest_q <= '0;
            for (int i = 0; i < NUM_DEST; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            fsm_q  <= fsm_d;
            hold_q <= hold_d;
            dest_q <= dest_d;
            for (int i = 0; i < NUM_DEST; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // The hold register is what the output FIFOs see, so data_out stays
    // stable through a stall and keeps the last word after delivery.
    assign data_out = hold_q;
    assign pop      = (fsm_q == S_FETCH);
    assign busy     = (fsm_q != S_IDLE);
    assign push0    = push_vec[0];
    assign push1    = push_vec[1];
    assign push2    = push_vec[2];
    assign push3    = push_vec[3];
    assign cnt0     = cnt_q[0];
    assign cnt1     = cnt_q[1];
    assign cnt2     = cnt_q[2];
    assign cnt3     = cnt_q[3];

endmodule

`default_nettype wire

// File: tb/tb_arbitro_destino.sv
// Testbench for arbitro_destino: directed scenarios followed by random traffic,
// checked every cycle against a transaction-level model of the word path.
`default_nettype none

module tb_arbitro_destino;

    localparam int DW = 6;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          reset_L;
    logic [3:0]    state;
    logic          empty_in;
    logic [DW-1:0] data_in;
    logic          almost_full0, almost_full1, almost_full2, almost_full3;
    logic          pop, push0, push1, push2, push3, busy;
    logic [DW-1:0] data_out;
    logic [CW-1:0] cnt0, cnt1, cnt2, cnt3;

    arbitro_destino #(.DATA_WIDTH(DW), .DEST_LSB(4), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_L(reset_L), .state(state), .empty_in(empty_in),
        .data_in(data_in), .almost_full0(almost_full0), .almost_full1(almost_full1),
        .almost_full2(almost_full2), .almost_full3(almost_full3), .pop(pop),
        .push0(push0), .push1(push1), .push2(push2), .push3(push3),
        .data_out(data_out), .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Intermediate FIFO contents and logs of observed activity
    logic [DW-1:0] fifo[$];
    int            pop_log[$];
    int            push_cyc[$];
    int            push_idx[$];
    logic [DW-1:0] push_dat[$];

    // Word-path model: at most one word in flight, deliverable two cycles
    // after its pop once the addressed FIFO is not almost full.
    bit            m_infl;
    int            m_age;
    logic [DW-1:0] m_word;
    logic [DW-1:0] m_last;
    int            m_cnt[4];
    bit            p_free;
    bit            p_can;
    logic          pop_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic observe();
        logic [3:0]    pushv, af, exp_push;
        logic [DW-1:0] exp_dout;
        logic [1:0]    d;
        bit            exp_pop, do_push;
        pushv = {push3, push2, push1, push0};
        af    = {almost_full3, almost_full2, almost_full1, almost_full0};
        if (!reset_L) begin
            check("rst_pop", pop, 0);
            check("rst_push", pushv, 0);
            check("rst_busy", busy, 0);
            check("rst_dout", data_out, 0);
            check("rst_cnt", {cnt3, cnt2, cnt1, cnt0}, 0);
            m_infl = 0;
            m_last = '0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            p_free = 1;
            p_can  = 0;
        end else begin
            exp_pop  = p_free && p_can;
            d        = m_word[5:4];
            do_push  = m_infl && (m_age >= 2) && !af[d];
            exp_push = do_push ? (4'b0001 << d) : 4'b0000;
            exp_dout = (m_infl && m_age >= 2) ? m_word : m_last;
            check("pop", pop, exp_pop);
            check("push", pushv, exp_push);
            check("data_out", data_out, exp_dout);
            check("busy", busy, exp_pop || m_infl);
            check("cnt0", cnt0, m_cnt[0]);
            check("cnt1", cnt1, m_cnt[1]);
            check("cnt2", cnt2, m_cnt[2]);
            check("cnt3", cnt3, m_cnt[3]);
            if (pop) begin
                check("pop_nonempty", fifo.size() != 0, 1);
                pop_log.push_back(cyc);
            end
            for (int i = 0; i < 4; i++) begin
                if (pushv[i]) begin
                    push_cyc.push_back(cyc);
                    push_idx.push_back(i);
                    push_dat.push_back(data_out);
                end
            end
            p_free = (!m_infl && !exp_pop) || do_push;
            p_can  = (state == 4'b1000) && !empty_in;
            if (m_infl && m_age >= 2) m_last = m_word;
            if (do_push) begin
                m_cnt[d] = (m_cnt[d] + 1) % 32;
                m_infl   = 0;
            end else if (m_infl) begin
                m_age++;
            end
            if (exp_pop) begin
                m_infl = 1;
                m_age  = 1;
                m_word = (fifo.size() != 0) ? fifo[0] : '0;
            end
        end
        pop_prev = pop;
        cyc++;
    endtask

    // Observe the current cycle, then move to just after the next edge and
    // let the intermediate FIFO respond to the pop seen in that cycle.
    task automatic tick();
        #1;
        observe();
        @(posedge clk);
        #1;
        if (pop_prev && fifo.size() != 0) data_in = fifo.pop_front();
        else data_in = DW'($urandom);
        empty_in = (fifo.size() == 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic put_word(input logic [DW-1:0] w);
        fifo.push_back(w);
        empty_in = 1'b0;
    endtask

    task automatic clear_logs();
        pop_log.delete();
        push_cyc.delete();
        push_idx.delete();
        push_dat.delete();
    endtask

    task automatic wait_pop(input int budget);
        int n = 0;
        int s = pop_log.size();
        while (pop_log.size() == s && n < budget) begin
            tick();
            n++;
        end
        check("wait_pop", pop_log.size() > s, 1);
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        ticks(2);
        reset_L = 1'b1;
    endtask

    task automatic set_af(input logic [3:0] v);
        {almost_full3, almost_full2, almost_full1, almost_full0} = v;
    endtask

    initial begin
        logic [DW-1:0] w;
        logic [DW-1:0] stream[4];
        int            t, n, r;
        reset_L  = 1'b0;
        state    = 4'b0001;
        empty_in = 1'b1;
        data_in  = '0;
        set_af(4'b0000);
        m_infl = 0; m_age = 0; m_word = '0; m_last = '0;
        p_free = 1; p_can = 0; pop_prev = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;

        // Power-on reset
        @(posedge clk);
        #1;
        check("init_pop", pop, 0);
        check("init_busy", busy, 0);
        check("init_dout", data_out, 0);
        ticks(2);
        reset_L = 1'b1;
        state   = 4'b0100;
        ticks(2);
        state   = 4'b1000;

        // Single word to destination 2
        clear_logs();
        put_word(6'b10_1011);
        ticks(8);
        check("single_npop", pop_log.size(), 1);
        check("single_npush", push_cyc.size(), 1);
        if (push_cyc.size() == 1 && pop_log.size() == 1) begin
            check("single_lat", push_cyc[0] - pop_log[0], 2);
            check("single_idx", push_idx[0], 2);
            check("single_data", push_dat[0], 6'h2B);
        end
        check("single_cnt2", cnt2, 1);
        check("single_idle", busy, 0);

        // Back-to-back stream, one word per destination
        do_reset();
        clear_logs();
        stream = '{6'h05, 6'h13, 6'h2A, 6'h3F};
        for (int i = 0; i < 4; i++) put_word(stream[i]);
        ticks(16);
        check("stream_npush", push_cyc.size(), 4);
        if (push_cyc.size() == 4 && pop_log.size() != 0) begin
            for (int i = 0; i < 4; i++) begin
                check("stream_time", push_cyc[i] - pop_log[0], 2 + 3 * i);
                check("stream_idx", push_idx[i], i);
                check("stream_data", push_dat[i], stream[i]);
            end
        end
        check("stream_cnts", {cnt3, cnt2, cnt1, cnt0}, {5'd1, 5'd1, 5'd1, 5'd1});

        // Backpressure on destination 3; almost_full0 must be ignored
        clear_logs();
        set_af(4'b1001);
        put_word(6'h3C);
        wait_pop(10);
        t = pop_log.size() != 0 ? pop_log[0] : 0;
        ticks(6);
        check("bp_stalled", push_cyc.size(), 0);
        #1;
        check("bp_hold", data_out, 6'h3C);
        set_af(4'b0001);
        tick();
        check("bp_npush", push_cyc.size(), 1);
        if (push_cyc.size() == 1) begin
            check("bp_time", push_cyc[0] - t, 7);
            check("bp_idx", push_idx[0], 3);
        end
        set_af(4'b0000);
        ticks(2);

        // Global state leaves ACTIVE while a word is being captured
        clear_logs();
        put_word(6'h01);
        put_word(6'h12);
        put_word(6'h23);
        wait_pop(10);
        state = 4'b0100;
        ticks(8);
        check("leave_npush", push_cyc.size(), 1);
        check("leave_npop", pop_log.size(), 1);
        check("leave_fifo", fifo.size(), 2);
        state = 4'b1000;
        ticks(10);
        check("resume_npush", push_cyc.size(), 3);

        // Asynchronous reset with a word stalled in delivery
        do_reset();
        put_word(6'h11);
        put_word(6'h1A);
        put_word(6'h1F);
        ticks(12);
        check("pre_rst_cnt1", cnt1, 3);
        set_af(4'b0010);
        put_word(6'h15);
        wait_pop(10);
        tick();
        #1;
        check("pre_rst_busy", busy, 1);
        reset_L = 1'b0;
        #1;
        check("arst_pop", pop, 0);
        check("arst_push", {push3, push2, push1, push0}, 0);
        check("arst_busy", busy, 0);
        check("arst_dout", data_out, 0);
        check("arst_cnt", {cnt3, cnt2, cnt1, cnt0}, 0);
        ticks(2);
        set_af(4'b0000);
        reset_L = 1'b1;
        clear_logs();
        ticks(4);
        check("post_rst_nopop", pop_log.size(), 0);
        check("post_rst_nopush", push_cyc.size(), 0);
        put_word(6'h07);
        ticks(5);
        check("post_rst_fetch", pop_log.size(), 1);

        // Counter wrap on destination 1
        do_reset();
        for (int i = 0; i < 33; i++) begin
            w = 6'h10 | DW'($urandom_range(0, 15));
            put_word(w);
        end
        n = 0;
        while ((fifo.size() != 0 || m_infl) && n < 200) begin
            tick();
            n++;
        end
        check("wrap_drained", fifo.size() == 0 && !m_infl, 1);
        ticks(2);
        check("wrap_cnt1", cnt1, 1);
        check("wrap_others", {cnt3, cnt2, cnt0}, 0);

        // Random traffic, backpressure and global state changes
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) put_word(DW'($urandom));
            set_af({($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)});
            r = $urandom_range(0, 9);
            state = (r < 7) ? 4'b1000 : ((r < 9) ? 4'b0100 : 4'b0010);
            tick();
        end
        set_af(4'b0000);
        state = 4'b1000;
        n = 0;
        while ((fifo.size() != 0 || m_infl) && n < 1500) begin
            tick();
            n++;
        end
        check("rand_drained", fifo.size() == 0 && !m_infl, 1);
        ticks(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
